// File: rtl/z16_decode_stage.sv
// Z16 instruction-decode pipeline stage: valid/ready handshake on both sides,
// register scoreboard for RAW/WAW hazard stalls, and a saturating stall counter.
module z16_decode_stage #(
   parameter int         IMM_W       = 16,
   parameter logic [3:0] ALU_OP_MAX  = 4'h9,
   parameter bit         SB_EN       = 1'b1,
   parameter int         STALL_CNT_W = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [15:0]            i_instr,
   input  logic                   i_valid,
   output logic                   o_ready,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [3:0]             o_opcode,
   output logic [3:0]             o_rd_addr,
   output logic [3:0]             o_rs1_addr,
   output logic [3:0]             o_rs2_addr,
   output logic [IMM_W-1:0]       o_imm,
   output logic                   o_rd_wen,
   output logic                   o_mem_wen,
   output logic [3:0]             o_alu_ctrl,
   output logic                   o_illegal,
   input  logic                   i_wb_en,
   input  logic [3:0]             i_wb_addr,
   output logic [15:0]            o_pending,
   output logic [STALL_CNT_W-1:0] o_stall_cnt
);

   localparam logic [3:0] OP_IMM = 4'hA;
   localparam logic [3:0] OP_ST  = 4'hB;

   function automatic logic [IMM_W-1:0] sext4(input logic [3:0] f);
      logic signed [IMM_W-1:0] r;
      r = $signed(f);
      return r;
   endfunction

   logic [3:0]       op;
   logic [3:0]       rd;
   logic [3:0]       rs1;
   logic [3:0]       rs2;
   logic             is_alu;
   logic             is_imm;
   logic             is_st;
   logic             d_rd_wen;
   logic             d_mem_wen;
   logic             d_illegal;
   logic [3:0]       d_alu_ctrl;
   logic [IMM_W-1:0] d_imm;
   logic             rd_rs1;
   logic             rd_rs2;
   logic             hazard;
   logic             accept;
   logic [15:0]      pend_nxt;

   assign op  = i_instr[3:0];
   assign rd  = i_instr[7:4];
   assign rs1 = i_instr[11:8];
   assign rs2 = i_instr[15:12];

   // ALU range takes priority so a large ALU_OP_MAX can swallow A/B.
   assign is_alu = (op <= ALU_OP_MAX);
   assign is_imm = !is_alu && (op == OP_IMM);
   assign is_st  = !is_alu && (op == OP_ST);

   always_comb begin
      d_rd_wen   = 1'b0;
      d_mem_wen  = 1'b0;
      d_illegal  = 1'b0;
      d_alu_ctrl = 4'h0;
      d_imm      = '0;
      rd_rs1     = 1'b0;
      rd_rs2     = 1'b0;
      unique case (1'b1)
         is_alu: begin
            d_rd_wen   = 1'b1;
            d_alu_ctrl = op;
            rd_rs1     = 1'b1;
            rd_rs2     = 1'b1;
         end
         is_imm: begin
            d_rd_wen = 1'b1;
            d_imm    = sext4(i_instr[15:12]);
            rd_rs1   = 1'b1;
         end
         is_st: begin
            d_mem_wen = 1'b1;
            d_imm     = sext4(i_instr[7:4]);
            rd_rs1    = 1'b1;
            rd_rs2    = 1'b1;
         end
         default: begin
            d_illegal = 1'b1;
         end
      endcase
   end

   // Registered scoreboard only: a same-cycle writeback does not bypass.
   always_comb begin
      hazard = 1'b0;
      if (SB_EN) begin
         hazard = (rd_rs1 && o_pending[rs1])
               || (rd_rs2 && o_pending[rs2])
               || (d_rd_wen && o_pending[rd]);
      end
   end

   assign o_ready = (!o_valid || i_ready) && !(i_valid && hazard);
   assign accept  = i_valid && o_ready;

   always_comb begin
      pend_nxt = o_pending;
      if (i_wb_en) pend_nxt[i_wb_addr] = 1'b0;
      if (accept && d_rd_wen) pend_nxt[rd] = 1'b1;
      if (!SB_EN) pend_nxt = '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid    <= 1'b0;
         o_opcode   <= 4'h0;
         o_rd_addr  <= 4'h0;
         o_rs1_addr <= 4'h0;
         o_rs2_addr <= 4'h0;
         o_imm      <= '0;
         o_rd_wen   <= 1'b0;
         o_mem_wen  <= 1'b0;
         o_alu_ctrl <= 4'h0;
         o_illegal  <= 1'b0;
      end else if (accept) begin
         o_valid    <= 1'b1;
         o_opcode   <= op;
         o_rd_addr  <= rd;
         o_rs1_addr <= rs1;
         o_rs2_addr <= rs2;
         o_imm      <= d_imm;
         o_rd_wen   <= d_rd_wen;
         o_mem_wen  <= d_mem_wen;
         o_alu_ctrl <= d_alu_ctrl;
         o_illegal  <= d_illegal;
      end else if (o_valid && i_ready) begin
         o_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_pending <= 16'h0000;
      end else begin
         o_pending <= pend_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_stall_cnt <= '0;
      end else if (i_valid && hazard && !(&o_stall_cnt)) begin
         o_stall_cnt <= o_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_z16_decode_stage.sv
// Bench for z16_decode_stage: directed steps then random traffic against a
// behavioural model; a second instance covers 8-bit imm and a 3-bit counter.
module tb_z16_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] instr = 16'h0;
   logic        valid = 1'b0;
   logic        ready = 1'b0;
   logic        wb_en = 1'b0;
   logic [3:0]  wb_addr = 4'h0;

   logic        rdy, ovalid, rd_wen, mem_wen, illegal;
   logic [3:0]  opcode, rd_addr, rs1_addr, rs2_addr, alu;
   logic [15:0] imm, pending, stall;

   logic        b_rdy, b_valid, b_rd_wen, b_mem_wen, b_illegal;
   logic [3:0]  b_opcode, b_rd_addr, b_rs1_addr, b_rs2_addr, b_alu;
   logic [7:0]  b_imm;
   logic [15:0] b_pending;
   logic [2:0]  b_stall;

   z16_decode_stage u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_valid(valid),
      .o_ready(rdy), .o_valid(ovalid), .i_ready(ready),
      .o_opcode(opcode), .o_rd_addr(rd_addr), .o_rs1_addr(rs1_addr),
      .o_rs2_addr(rs2_addr), .o_imm(imm), .o_rd_wen(rd_wen),
      .o_mem_wen(mem_wen), .o_alu_ctrl(alu), .o_illegal(illegal),
      .i_wb_en(wb_en), .i_wb_addr(wb_addr), .o_pending(pending),
      .o_stall_cnt(stall)
   );

   z16_decode_stage #(.IMM_W(8), .STALL_CNT_W(3)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_valid(valid),
      .o_ready(b_rdy), .o_valid(b_valid), .i_ready(ready),
      .o_opcode(b_opcode), .o_rd_addr(b_rd_addr), .o_rs1_addr(b_rs1_addr),
      .o_rs2_addr(b_rs2_addr), .o_imm(b_imm), .o_rd_wen(b_rd_wen),
      .o_mem_wen(b_mem_wen), .o_alu_ctrl(b_alu), .o_illegal(b_illegal),
      .i_wb_en(wb_en), .i_wb_addr(wb_addr), .o_pending(b_pending),
      .o_stall_cnt(b_stall)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [3:0]  op, rd, rs1, rs2, alu;
      logic [15:0] imm;
      logic        wen, men, ill, r1, r2;
   } dec_t;

   dec_t m_out;
   bit   m_valid;
   bit   m_pend[16];
   int   m_stall;
   bit   m_rdy;
   bit   last_acc;

   function automatic int sx(input logic [3:0] f);
      int v;
      v = int'(f);
      if (v > 7) v = v - 16;
      return v;
   endfunction

   function automatic dec_t decode(input logic [15:0] ins);
      dec_t d;
      d.op = ins[3:0]; d.rd = ins[7:4]; d.rs1 = ins[11:8]; d.rs2 = ins[15:12];
      d.alu = 0; d.imm = 0; d.wen = 0; d.men = 0; d.ill = 0; d.r1 = 0; d.r2 = 0;
      if (d.op <= 9) begin
         d.wen = 1; d.alu = d.op; d.r1 = 1; d.r2 = 1;
      end else if (d.op == 10) begin
         d.wen = 1; d.r1 = 1; d.imm = 16'(sx(ins[15:12]));
      end else if (d.op == 11) begin
         d.men = 1; d.r1 = 1; d.r2 = 1; d.imm = 16'(sx(ins[7:4]));
      end else begin
         d.ill = 1;
      end
      return d;
   endfunction

   function automatic bit hz(input logic [15:0] ins);
      dec_t d;
      d = decode(ins);
      return (d.r1 && m_pend[d.rs1]) || (d.r2 && m_pend[d.rs2])
          || (d.wen && m_pend[d.rd]);
   endfunction

   function automatic logic [15:0] pend_vec();
      logic [15:0] p;
      for (int i = 0; i < 16; i++) p[i] = m_pend[i];
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0;
      m_stall = 0;
      last_acc = 0;
      for (int i = 0; i < 16; i++) m_pend[i] = 0;
   endtask

   task automatic step();
      dec_t d;
      bit   h, acc;
      #1;
      h = valid && hz(instr);
      m_rdy = (!m_valid || ready) && !h;
      chk("o_ready", rdy, m_rdy);
      chk("b_ready", b_rdy, m_rdy);
      @(posedge clk);
      d = decode(instr);
      acc = valid && m_rdy;
      if (h) m_stall++;
      if (acc) begin
         m_out = d;
         m_valid = 1;
      end else if (m_valid && ready) begin
         m_valid = 0;
      end
      if (wb_en) m_pend[wb_addr] = 0;
      if (acc && d.wen) m_pend[d.rd] = 1;
      last_acc = acc;
      #1;
      chk("o_valid", ovalid, m_valid);
      chk("b_valid", b_valid, m_valid);
      chk("o_pending", pending, pend_vec());
      chk("o_stall_cnt", stall, (m_stall > 65535) ? 65535 : m_stall);
      chk("b_stall_cnt", b_stall, (m_stall > 7) ? 7 : m_stall);
      if (m_valid) begin
         chk("o_opcode", opcode, m_out.op);
         chk("o_rd_addr", rd_addr, m_out.rd);
         chk("o_rs1_addr", rs1_addr, m_out.rs1);
         chk("o_rs2_addr", rs2_addr, m_out.rs2);
         chk("o_imm", imm, m_out.imm);
         chk("b_imm", b_imm, m_out.imm[7:0]);
         chk("o_rd_wen", rd_wen, m_out.wen);
         chk("o_mem_wen", mem_wen, m_out.men);
         chk("o_alu_ctrl", alu, m_out.alu);
         chk("o_illegal", illegal, m_out.ill);
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", ovalid, 0);
      chk("rst_pending", pending, 0);
      chk("rst_stall", stall, 0);
      chk("rst_imm", imm, 0);
      chk("rst_opcode", opcode, 0);
      rst_n = 1'b1;

      ready = 1; valid = 1; instr = 16'h2153;
      step();
      chk("t1_alu", alu, 3);
      chk("t1_wen", rd_wen, 1);
      chk("t1_pend", pending, 16'h0020);

      instr = 16'hF14A;
      step();
      chk("t2_imm", imm, 16'hFFFF);
      chk("t2_imm8", b_imm, 8'hFF);
      chk("t2_rd", rd_addr, 4);

      instr = 16'h537B;
      #0;
      chk("t3_blocked", rdy, 0);
      step();
      step();
      step();
      chk("t3_stall3", stall, 3);
      wb_en = 1; wb_addr = 5;
      step();
      wb_en = 0;
      chk("t3_stall4", stall, 4);
      chk("t3_rdy_after_wb", rdy, 1);
      step();
      chk("t3_imm", imm, 16'h0007);
      chk("t3_mem_wen", mem_wen, 1);
      chk("t3_stall_hold", stall, 4);

      ready = 0; instr = 16'h0060;
      step();
      step();
      chk("t4_hold_op", opcode, 4'hB);
      ready = 1;
      step();
      chk("t4_no_bubble", opcode, 0);
      chk("t4_rd", rd_addr, 6);

      instr = 16'h000E;
      step();
      chk("t5_illegal", illegal, 1);
      chk("t5_wen", rd_wen, 0);
      chk("t5_pend", pending, 16'h0050);

      instr = 16'h0030; wb_en = 1; wb_addr = 3;
      step();
      wb_en = 0;
      chk("t6_set_wins", pending, 16'h0058);

      for (int n = 0; n < 400; n++) begin
         if (!(valid && !last_acc)) begin
            valid = ($urandom_range(0, 3) != 0);
            instr = 16'($urandom);
         end
         ready = ($urandom_range(0, 3) != 0);
         wb_en = $urandom_range(0, 1) == 1;
         wb_addr = 4'($urandom);
         step();
      end

      valid = 0; ready = 1;
      for (int i = 0; i < 16; i++) begin
         wb_en = 1; wb_addr = 4'(i);
         step();
      end
      wb_en = 0; valid = 1; instr = 16'h0070;
      step();
      valid = 0;
      chk("t7_pre_valid", ovalid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_valid", ovalid, 0);
      chk("t7_rst_pend", pending, 0);
      chk("t7_rst_stall", stall, 0);
      model_reset();
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      valid = 1; instr = 16'h21A1;
      step();
      valid = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
